// File: rtl/la_iopwrseq.sv
`default_nettype none
// ============================================================================
// la_iopwrseq : IO-ring supply sequencer, ordered power-up / reverse power-down
// Revision    : 1.0
// ============================================================================
module la_iopwrseq #(
   parameter int N        = 3,
   parameter     SIDE     = "NO",
   parameter int CW       = 8,
   parameter int DELAY    = 4,
   parameter int DEBOUNCE = 2,
   parameter int TIMEOUT  = 16
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start_i,
   input  logic                               stop_i,
   input  logic [N-1:0]                       pgood_i,
   output logic [N-1:0]                       en_o,
   output logic [2:0]                         state_o,
   output logic                               busy_o,
   output logic                               done_o,
   output logic                               fault_o,
   output logic [((N > 1) ? $clog2(N) : 1)-1:0] fault_idx_o
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RAMP   = 3'd1,
      S_SETTLE = 3'd2,
      S_ON     = 3'd3,
      S_DOWN   = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [IW-1:0]       fidx_q, fidx_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N-1:0]        en_q, en_d;
   logic                busy_q, done_q, fault_q;

   logic [N-1:0]        sync1_q, pgood_s_q;
   logic [N-1:0]        last_q;
   logic [N-1:0][CW-1:0] run_q, run_d;
   logic [N-1:0]        deb_hi, deb_lo;
   logic                bo_hit;
   logic [IW-1:0]       bo_idx;

   // Per-channel run-length of the current synced level, saturating at DEBOUNCE
   always_comb begin
      run_d  = run_q;
      deb_hi = '0;
      deb_lo = '0;
      for (int i = 0; i < N; i++) begin
         if (pgood_s_q[i] != last_q[i]) begin
            run_d[i] = CW'(1);
         end else if (run_q[i] == CW'(DEBOUNCE)) begin
            run_d[i] = run_q[i];
         end else begin
            run_d[i] = run_q[i] + CW'(1);
         end
         deb_hi[i] = pgood_s_q[i] & (run_d[i] == CW'(DEBOUNCE));
         deb_lo[i] = ~pgood_s_q[i] & (run_d[i] == CW'(DEBOUNCE));
      end
   end

   always_comb begin
      bo_hit = 1'b0;
      bo_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (en_q[i] && deb_lo[i]) begin
            bo_hit = 1'b1;
            bo_idx = IW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      fidx_d  = fidx_q;
      cnt_d   = cnt_q + CW'(1);
      en_d    = en_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!stop_i && start_i) begin
               state_d  = S_RAMP;
               idx_d    = '0;
               en_d     = '0;
               en_d[0]  = 1'b1;
            end
         end
         S_RAMP: begin
            if (stop_i) begin
               state_d     = S_DOWN;
               en_d[idx_q] = 1'b0;
               cnt_d       = '0;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = S_FAULT;
               en_d    = '0;
               fidx_d  = idx_q;
               cnt_d   = '0;
            end else if (deb_hi[idx_q]) begin
               cnt_d   = '0;
               state_d = (idx_q == IW'(N - 1)) ? S_ON : S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (stop_i) begin
               state_d     = S_DOWN;
               en_d[idx_q] = 1'b0;
               cnt_d       = '0;
            end else if (cnt_q == CW'(DELAY - 1)) begin
               state_d     = S_RAMP;
               idx_d       = idx_q + IW'(1);
               en_d[idx_d] = 1'b1;
               cnt_d       = '0;
            end
         end
         S_ON: begin
            cnt_d = '0;
            if (stop_i) begin
               state_d     = S_DOWN;
               en_d[idx_q] = 1'b0;
            end else if (bo_hit) begin
               state_d = S_FAULT;
               en_d    = '0;
               fidx_d  = bo_idx;
            end
         end
         S_DOWN: begin
            // After channel 0 is cleared, one more DELAY elapses before IDLE
            if (cnt_q == CW'(DELAY - 1)) begin
               cnt_d = '0;
               if (idx_q == '0) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d       = idx_q - IW'(1);
                  en_d[idx_d] = 1'b0;
               end
            end
         end
         S_FAULT: begin
            cnt_d = '0;
            en_d  = '0;
            if (stop_i) begin
               state_d = S_IDLE;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            en_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= '0;
         pgood_s_q <= '0;
         last_q    <= '0;
         run_q     <= '0;
         state_q   <= S_IDLE;
         idx_q     <= '0;
         fidx_q    <= '0;
         cnt_q     <= '0;
         en_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         sync1_q   <= pgood_i;
         pgood_s_q <= sync1_q;
         last_q    <= pgood_s_q;
         run_q     <= run_d;
         state_q   <= state_d;
         idx_q     <= idx_d;
         fidx_q    <= fidx_d;
         cnt_q     <= cnt_d;
         en_q      <= en_d;
         busy_q    <= (state_d == S_RAMP) || (state_d == S_SETTLE) || (state_d == S_DOWN);
         done_q    <= (state_d == S_ON);
         fault_q   <= (state_d == S_FAULT);
      end
   end

   assign en_o        = en_q;
   assign state_o     = state_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign fault_o     = fault_q;
   assign fault_idx_o = fidx_q;

endmodule
`default_nettype wire
